// File: rtl/cpu_host_ctrl.sv
// cpu_host_ctrl: host-side run controller for the A-RISC core.
// Loads IRAM/DRAM from a host stream, runs the CPU under a watchdog,
// and streams DRAM bytes back out. Owns and muxes both RAM ports.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cmd_*              host command handshake (op, start addr, length)
//   s_*                input word stream (LOAD_I / LOAD_D payload)
//   m_*                output byte stream (READ_D payload)
//   busy, done, err    status; err qualifies done (watchdog expiry)
//   cpu_start          start pulse to the CPU
//   cpu_idle           CPU idle flag
//   cpu_iram_addr      CPU instruction fetch address
//   cpu_dram_*         CPU data RAM request (addr, wdata, write)
//   iram_*             instruction RAM port (addr, wdata, write)
//   dram_*             data RAM port (addr, wdata, write, rdata)
module cpu_host_ctrl #(
    parameter int W          = 8,
    parameter int MAX_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [W-1:0]  cmd_addr,
    input  logic [W-1:0]  cmd_len,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [15:0]   s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cpu_start,
    input  logic          cpu_idle,
    input  logic [W-1:0]  cpu_iram_addr,
    input  logic [W-1:0]  cpu_dram_addr,
    input  logic [W-1:0]  cpu_dram_din,
    input  logic          cpu_dram_write,
    output logic [W-1:0]  iram_addr,
    output logic [15:0]   iram_din,
    output logic          iram_write,
    output logic [W-1:0]  dram_addr,
    output logic [W-1:0]  dram_din,
    output logic          dram_write,
    input  logic [W-1:0]  dram_dout
);

    localparam int WDW = $clog2(MAX_CYCLES) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(MAX_CYCLES - 1);

    localparam logic [1:0] OP_LOAD_I = 2'd0;
    localparam logic [1:0] OP_LOAD_D = 2'd1;
    localparam logic [1:0] OP_RUN    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_D,
        S_RUN_START,
        S_RUN_WAIT,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [W-1:0]   addr_r;
    logic [W-1:0]   cnt_r;
    logic [W-1:0]   m_data_r;
    logic [WDW-1:0] wd_cnt;
    logic           seen_busy;
    logic           err_r;
    logic           rd_first;

    logic cmd_fire;
    logic step;
    logic wd_fire;
    logic cpu_owns;
    logic load_i_we;
    logic load_d_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        done      = 1'b0;
        cpu_start = 1'b0;
        cpu_owns  = 1'b0;
        cmd_fire  = 1'b0;
        step      = 1'b0;
        wd_fire   = 1'b0;
        load_i_we = 1'b0;
        load_d_we = 1'b0;

        unique case (state)
            S_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_fire = 1'b1;
                    if (cmd_op == OP_RUN) begin
                        state_nxt = S_RUN_START;
                    end else if (cmd_len == '0) begin
                        state_nxt = S_DONE;
                    end else if (cmd_op == OP_LOAD_I) begin
                        state_nxt = S_LOAD_I;
                    end else if (cmd_op == OP_LOAD_D) begin
                        state_nxt = S_LOAD_D;
                    end else begin
                        state_nxt = S_RD_ADDR;
                    end
                end
            end

            S_LOAD_I: begin
                s_ready   = 1'b1;
                load_i_we = s_valid;
                step      = s_valid;
                if (s_valid && cnt_r == W'(1)) begin
                    state_nxt = S_DONE;
                end
            end

            S_LOAD_D: begin
                s_ready   = 1'b1;
                load_d_we = s_valid;
                step      = s_valid;
                if (s_valid && cnt_r == W'(1)) begin
                    state_nxt = S_DONE;
                end
            end

            S_RUN_START: begin
                cpu_owns  = 1'b1;
                cpu_start = 1'b1;
                state_nxt = S_RUN_WAIT;
            end

            S_RUN_WAIT: begin
                cpu_owns = 1'b1;
                // A clean finish wins over expiry in the same cycle.
                if (seen_busy && cpu_idle) begin
                    state_nxt = S_DONE;
                end else if (wd_cnt == WD_LAST) begin
                    wd_fire   = 1'b1;
                    state_nxt = S_DONE;
                end
            end

            S_RD_ADDR: begin
                state_nxt = S_RD_DATA;
            end

            S_RD_DATA: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    step = 1'b1;
                    if (cnt_r == W'(1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_RD_ADDR;
                    end
                end
            end

            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r    <= '0;
            cnt_r     <= '0;
            wd_cnt    <= '0;
            seen_busy <= 1'b0;
            err_r     <= 1'b0;
            m_data_r  <= '0;
            rd_first  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                addr_r <= cmd_addr;
                cnt_r  <= cmd_len;
            end else if (step) begin
                addr_r <= addr_r + W'(1);
                cnt_r  <= cnt_r - W'(1);
            end

            if (state == S_RUN_START) begin
                wd_cnt    <= '0;
                seen_busy <= 1'b0;
            end else if (state == S_RUN_WAIT) begin
                wd_cnt <= wd_cnt + WDW'(1);
                if (!cpu_idle) begin
                    seen_busy <= 1'b1;
                end
            end

            if (state != S_DONE && state_nxt == S_DONE) begin
                err_r <= wd_fire;
            end

            // RAM data is valid in the first RD_DATA cycle; it is
            // shown directly then and held from the register after.
            rd_first <= (state == S_RD_ADDR);
            if (rd_first) begin
                m_data_r <= dram_dout;
            end
        end
    end

    assign m_data     = rd_first ? dram_dout : m_data_r;
    assign err        = (state == S_DONE) & err_r;

    assign iram_addr  = cpu_owns ? cpu_iram_addr : addr_r;
    assign iram_din   = s_data;
    assign iram_write = load_i_we;

    assign dram_addr  = cpu_owns ? cpu_dram_addr : addr_r;
    assign dram_din   = cpu_owns ? cpu_dram_din : s_data[W-1:0];
    assign dram_write = cpu_owns ? cpu_dram_write : load_d_we;

endmodule
